pipe_adder_rca: RTL and testbench
=================================

PIPE_ADDER_RCA -- requirements
Module: pipe_adder_rca

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, number of pipeline stages (1..WIDTH); slice width W_S = WIDTH/STAGES.
REQ-003 Port list SHALL be, clock and reset first:
  clk        input   1      single clock, all state on rising edge
  rst_n      input   1      asynchronous active-low reset
  in_valid   input   1      operand beat present
  in_ready   output  1      block can accept operand beat
  a          input   WIDTH  operand A
  b          input   WIDTH  operand B
  cin        input   1      carry in (ignored when sub=1)
  sub        input   1      0: a+b+cin; 1: a-b
  out_valid  output  1      result beat present
  out_ready  input   1      downstream accepts result
  sum        output  WIDTH  result
  carry      output  1      carry out (sub=1: 1 = no borrow)
  ovf        output  1      signed overflow (present only with PIPE_ADDER_RCA_OVF_EN)
REQ-004 One clock, reset asynchronous and active-low; ports named clk and rst_n.

Function
REQ-005 Result SHALL equal {carry,sum} = a + b + cin for sub=0, and a + ~b + 1 (WIDTH+1 bits) for sub=1.
REQ-006 Carry chain SHALL be split into STAGES slices of W_S bits; stage k adds slice k and registers its carry into stage k+1; untouched upper operand slices and sub are delayed alongside (skew registers).
REQ-007 Beat accepted when in_valid && in_ready at a rising edge.
REQ-008 Global advance = out_ready || !out_valid; in_ready SHALL equal advance (combinational); all stage registers update only when advance=1.
REQ-009 Latency: beat accepted at edge T appears with out_valid=1 after edge T+STAGES-1 (STAGES edges including acceptance edge), given no stall.
REQ-010 Throughput: one beat per cycle while out_ready=1; bubbles (in_valid=0) propagate as valid=0 stages, order preserved.
REQ-011 Stall: out_valid=1 && out_ready=0 SHALL freeze the whole pipeline; sum/carry/out_valid hold stable; no beat lost or duplicated.
REQ-012 Simultaneous output handshake and input acceptance in same cycle SHALL both occur.
REQ-013 Wrap-around: all-ones + 1 SHALL give sum=0, carry=1; 0 - 1 SHALL give sum=all-ones, carry=0.
REQ-014 a, b, cin, sub SHALL be ignored when not accepted (in_valid=0 or in_ready=0).
REQ-015 STAGES=1 SHALL degrade to single registered adder, latency 1.

Reset
REQ-016 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, sum=0, carry=0, ovf=0.
REQ-017 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.
REQ-018 First acceptance possible at first rising edge with rst_n high; in_ready=1 out of reset.

Configuration
REQ-019 Macro PIPE_ADDER_RCA_OVF_EN defined: ovf port exists, ovf = signed overflow of the selected operation (operands two's complement), aligned with sum, holds under stall.
REQ-020 Macro undefined: no ovf port, no overflow logic; all other behaviour identical.

Verification (WIDTH=16, STAGES=4)
REQ-021 a=16'h1234, b=16'h4321, cin=1, sub=0, out_ready=1 -> sum=16'h5556, carry=0, out_valid exactly 4 edges after acceptance.
REQ-022 a=16'hFFFF, b=0, cin=1 -> sum=0, carry=1; sub=1, a=0, b=1 -> sum=16'hFFFF, carry=0; with OVF_EN, a=16'h7FFF, b=1, sub=0 -> ovf=1.
REQ-023 Back-to-back 1000 random beats, out_ready=1 -> results match model in order, one per cycle.
REQ-024 out_ready=0 for 5 cycles with full pipe -> in_ready=0, outputs stable; release -> 4 pending beats emerge consecutively, none lost.
REQ-025 rst_n pulsed low asynchronously (mid-cycle) with 3 beats in flight -> out_valid=0, sum=0 immediately; no stale beat after release.
REQ-026 Repeat REQ-021/023 with STAGES=1 and STAGES=16 -> latency 1 and 16 respectively, results correct.

Source files
------------

// File: rtl/pipe_adder_rca.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder_rca
// Brief    : Pipelined ripple-carry adder/subtractor; one carry slice per
//            stage, upper operand slices skewed alongside. Define
//            PIPE_ADDER_RCA_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0  initial release
// ============================================================================
module pipe_adder_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef PIPE_ADDER_RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_slice_w = WIDTH / STAGES;

    logic             w_advance;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    // The whole pipe moves as one; it only freezes on a stalled result.
    assign w_advance = out_ready | ~r_out_valid;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-k*c_slice_w-1:0] w_a;
        logic [WIDTH-k*c_slice_w-1:0] w_b;
        logic                         w_c;
        logic                         w_v;
        logic [c_slice_w:0]           w_slice;
        logic [(k+1)*c_slice_w-1:0]   w_sum;

        if (k == 0) begin : g_head
            // Subtraction is folded in here: invert b and force carry-in.
            assign w_a   = a;
            assign w_b   = sub ? ~b : b;
            assign w_c   = sub | cin;
            assign w_v   = in_valid;
            assign w_sum = w_slice[c_slice_w-1:0];
        end else begin : g_body
            logic [WIDTH-k*c_slice_w-1:0] r_a;
            logic [WIDTH-k*c_slice_w-1:0] r_b;
            logic [k*c_slice_w-1:0]       r_sum_lo;
            logic                         r_c;
            logic                         r_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v      <= 1'b0;
                    r_c      <= 1'b0;
                    r_a      <= '0;
                    r_b      <= '0;
                    r_sum_lo <= '0;
                end else if (w_advance) begin
                    r_v      <= g_stage[k-1].w_v;
                    r_c      <= g_stage[k-1].w_slice[c_slice_w];
                    r_a      <= g_stage[k-1].w_a[WIDTH-(k-1)*c_slice_w-1:c_slice_w];
                    r_b      <= g_stage[k-1].w_b[WIDTH-(k-1)*c_slice_w-1:c_slice_w];
                    r_sum_lo <= g_stage[k-1].w_sum;
                end
            end

            assign w_a   = r_a;
            assign w_b   = r_b;
            assign w_c   = r_c;
            assign w_v   = r_v;
            assign w_sum = {w_slice[c_slice_w-1:0], r_sum_lo};
        end

        assign w_slice = {1'b0, w_a[c_slice_w-1:0]}
                       + {1'b0, w_b[c_slice_w-1:0]}
                       + {{c_slice_w{1'b0}}, w_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= g_stage[STAGES-1].w_v;
            r_sum       <= g_stage[STAGES-1].w_sum;
            r_carry     <= g_stage[STAGES-1].w_slice[c_slice_w];
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;

`ifdef PIPE_ADDER_RCA_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Operands of equal sign giving a result of the other sign overflowed.
    assign w_ovf = (g_stage[STAGES-1].w_a[c_slice_w-1] == g_stage[STAGES-1].w_b[c_slice_w-1])
                && (g_stage[STAGES-1].w_slice[c_slice_w-1] != g_stage[STAGES-1].w_a[c_slice_w-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder_rca.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder_rca
// Brief    : Scoreboard bench for pipe_adder_rca at STAGES = 1, 4 and 16.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_adder_rca;

    localparam int c_n = 3;
    localparam int c_w = 16;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        int          acc;
        int          stl;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin       = 1'b0;
    logic        sub       = 1'b0;
    logic [15:0] a         = '0;
    logic [15:0] b         = '0;

    logic [c_n-1:0]       ir;
    logic [c_n-1:0]       ov;
    logic [c_n-1:0]       cy;
    logic [c_n-1:0][15:0] sm;
`ifdef PIPE_ADDER_RCA_OVF_EN
    logic [c_n-1:0]       of;
`endif

    exp_t        q[c_n][$];
    int          total     = 0;
    int          bad       = 0;
    int          cyc       = 0;
    int          stall_cnt = 0;
    logic        prev_stall[c_n];
    logic [15:0] prev_sm[c_n];
    logic        prev_cy[c_n];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < c_n; i++) begin : g_dut
        localparam int c_s = (i == 0) ? 1 : ((i == 1) ? 4 : 16);
        pipe_adder_rca #(.WIDTH(c_w), .STAGES(c_s)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir[i]),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(ov[i]),
            .out_ready(out_ready),
            .sum      (sm[i]),
            .carry    (cy[i])
`ifdef PIPE_ADDER_RCA_OVF_EN
            ,
            .ovf      (of[i])
`endif
        );
    end

    function automatic int stg_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mc, input logic ms);
        exp_t e;
        int   ua = int'(ma);
        int   ub = int'(mb);
        int   sa = int'($signed(ma));
        int   sb = int'($signed(mb));
        int   u;
        int   s;
        if (ms) begin
            u       = ua - ub;
            e.carry = (ua >= ub);
            s       = sa - sb;
        end else begin
            u       = ua + ub + int'(mc);
            e.carry = (u > 65535);
            s       = sa + sb + int'(mc);
        end
        e.sum = 16'(u);
        e.ovf = (s > 32767) || (s < -32768);
        e.acc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor/scoreboard: accepted beats are modelled, results popped in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_n; i++) begin
                q[i].delete();
                prev_stall[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < c_n; i++) begin
                if (ov[i] && !out_ready) begin
                    chk($sformatf("stall_in_ready[s%0d]", stg_of(i)), ir[i], 0);
                    if (prev_stall[i]) begin
                        chk($sformatf("stall_sum[s%0d]", stg_of(i)), sm[i], prev_sm[i]);
                        chk($sformatf("stall_carry[s%0d]", stg_of(i)), cy[i], prev_cy[i]);
                    end
                    prev_stall[i] = 1'b1;
                    prev_sm[i]    = sm[i];
                    prev_cy[i]    = cy[i];
                end else begin
                    prev_stall[i] = 1'b0;
                end
                if (ov[i] && out_ready) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_beat[s%0d]", stg_of(i)), ov[i], 0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk($sformatf("sum[s%0d]", stg_of(i)), sm[i], e.sum);
                        chk($sformatf("carry[s%0d]", stg_of(i)), cy[i], e.carry);
`ifdef PIPE_ADDER_RCA_OVF_EN
                        chk($sformatf("ovf[s%0d]", stg_of(i)), of[i], e.ovf);
`endif
                        if (e.stl == stall_cnt)
                            chk($sformatf("latency[s%0d]", stg_of(i)), cyc - e.acc, stg_of(i));
                    end
                end
                if (in_valid && ir[i]) begin
                    exp_t e;
                    e     = model(a, b, cin, sub);
                    e.acc = cyc;
                    e.stl = stall_cnt;
                    q[i].push_back(e);
                end
            end
            if (!out_ready) stall_cnt++;
        end
    end

    task automatic drive(input logic v, input logic [15:0] da, input logic [15:0] db,
                         input logic dc, input logic ds, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = da;
        b         = db;
        cin       = dc;
        sub       = ds;
        out_ready = ordy;
    endtask

    task automatic drive_rnd(input logic v, input logic ordy);
        drive(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    initial begin
        int stale;
        int busy;

        #2;
        for (int i = 0; i < c_n; i++) begin
            chk($sformatf("reset_out_valid[s%0d]", stg_of(i)), ov[i], 0);
            chk($sformatf("reset_sum[s%0d]", stg_of(i)), sm[i], 0);
            chk($sformatf("reset_carry[s%0d]", stg_of(i)), cy[i], 0);
            chk($sformatf("reset_in_ready[s%0d]", stg_of(i)), ir[i], 1);
        end
        #10 rst_n = 1'b1;

        // Directed corner beats, then a gap.
        drive(1, 16'h1234, 16'h4321, 1, 0, 1);
        drive(1, 16'hFFFF, 16'h0000, 1, 0, 1);
        drive(1, 16'h0000, 16'h0001, 0, 1, 1);
        drive(1, 16'h7FFF, 16'h0001, 0, 0, 1);
        drive(1, 16'h8000, 16'h0001, 1, 1, 1);
        drive(1, 16'h0005, 16'h0005, 0, 1, 1);
        repeat (20) drive_rnd(0, 1);

        // Back-to-back random beats.
        repeat (1000) drive_rnd(1, 1);

        // Full pipe, then a five-cycle stall and release.
        repeat (20) drive_rnd(1, 1);
        repeat (5) drive_rnd(1, 0);
        repeat (20) drive_rnd(1, 1);

        // Random valid and backpressure mix.
        repeat (1000) drive_rnd(($urandom % 10) < 7, ($urandom % 10) < 7);
        repeat (30) drive_rnd(0, 1);

        // Asynchronous reset with beats in flight.
        repeat (3) drive_rnd(1, 1);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < c_n; i++) begin
            chk($sformatf("midreset_out_valid[s%0d]", stg_of(i)), ov[i], 0);
            chk($sformatf("midreset_sum[s%0d]", stg_of(i)), sm[i], 0);
            chk($sformatf("midreset_carry[s%0d]", stg_of(i)), cy[i], 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        stale = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            for (int i = 0; i < c_n; i++) if (ov[i]) stale++;
        end
        chk("stale_after_reset", stale, 0);

        // Traffic after reset, then bounded drain.
        repeat (40) drive_rnd(1, 1);
        drive_rnd(0, 1);
        busy = 1;
        for (int t = 0; t < 200 && busy != 0; t++) begin
            @(negedge clk);
            busy = 0;
            for (int i = 0; i < c_n; i++) busy += q[i].size();
        end
        for (int i = 0; i < c_n; i++)
            chk($sformatf("drain_pending[s%0d]", stg_of(i)), q[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
